// File: rtl/inst_pair_queue_if.sv
// Fetch-to-decode instruction pair interface: pair in, two-slot head view out.
// The queue takes the slave modport; the fetch/decode side drives the master modport.
interface inst_pair_queue_if #(
   parameter int DEPTH = 8
);
   logic                         flush;
   logic                         in_valid;
   logic [31:0]                  in_pc;
   logic [31:0]                  in_inst_a;
   logic [31:0]                  in_inst_b;
   logic                         stall;
   logic [1:0]                   deq_count;
   logic                         out_valid_a;
   logic [31:0]                  out_pc_a;
   logic [31:0]                  out_inst_a;
   logic                         out_valid_b;
   logic [31:0]                  out_pc_b;
   logic [31:0]                  out_inst_b;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport master (
      output flush, in_valid, in_pc, in_inst_a, in_inst_b, deq_count,
      input  stall, out_valid_a, out_pc_a, out_inst_a,
             out_valid_b, out_pc_b, out_inst_b, count
   );

   modport slave (
      input  flush, in_valid, in_pc, in_inst_a, in_inst_b, deq_count,
      output stall, out_valid_a, out_pc_a, out_inst_a,
             out_valid_b, out_pc_b, out_inst_b, count
   );
endinterface

// File: rtl/inst_pair_queue.sv
// Instruction queue between dual-issue fetch and decode: pair in per cycle, FWFT two-slot head out.
// Enqueued pair visible the cycle after; stall to fetch is conservative (count > DEPTH-2).
module inst_pair_queue #(
   parameter int          DEPTH = 8,
   parameter logic [31:0] NOP   = 32'h00000013
) (
   input  logic            clk,
   input  logic            reset,
   inst_pair_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW-1:0] head_p1;
   logic [PW-1:0] tail_p1;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic [CW-1:0] eff;
   logic [1:0]    req;
   logic          enq;

   assign head_p1 = head + PW'(1);
   assign tail_p1 = tail + PW'(1);

   assign q.stall = (cnt > CW'(DEPTH-2));
   assign enq     = q.in_valid && !q.stall && !q.flush;

   // Decode may over-ask; clamp to what is actually held so head never passes tail.
   always_comb begin
      req      = (q.deq_count == 2'd3) ? 2'd2 : q.deq_count;
      eff      = (CW'(req) > cnt) ? cnt : CW'(req);
      cnt_next = cnt + (enq ? CW'(2) : CW'(0)) - eff;
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         pc_mem[tail]      <= q.in_pc;
         inst_mem[tail]    <= q.in_inst_a;
         pc_mem[tail_p1]   <= q.in_pc + 32'd4;
         inst_mem[tail_p1] <= q.in_inst_b;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else if (q.flush) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         head <= head + PW'(eff);
         if (enq)
            tail <= tail + PW'(2);
         cnt  <= cnt_next;
      end
   end

   always_comb begin
      q.count       = cnt;
      q.out_valid_a = (cnt >= CW'(1));
      q.out_valid_b = (cnt >= CW'(2));
      q.out_pc_a    = q.out_valid_a ? pc_mem[head]      : 32'd0;
      q.out_inst_a  = q.out_valid_a ? inst_mem[head]    : NOP;
      q.out_pc_b    = q.out_valid_b ? pc_mem[head_p1]   : 32'd0;
      q.out_inst_b  = q.out_valid_b ? inst_mem[head_p1] : NOP;
   end
endmodule

// File: tb/tb_inst_pair_queue.sv
// Randomized scoreboard bench for inst_pair_queue against a queue-based reference model.
module tb_inst_pair_queue;
   localparam int          DEPTH = 8;
   localparam logic [31:0] NOP   = 32'h00000013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   typedef struct {
      logic        va;
      logic [31:0] pa;
      logic [31:0] ia;
      logic        vb;
      logic [31:0] pb;
      logic [31:0] ib;
      logic [3:0]  cnt;
      logic        st;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;
   ent_t mq[$];
   exp_t exp_q[$];

   inst_pair_queue_if #(.DEPTH(DEPTH)) bus ();

   inst_pair_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
      .clk   (clk),
      .reset (reset),
      .q     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endfunction

   function automatic exp_t model_view();
      exp_t e;
      e.va  = (mq.size() >= 1);
      e.vb  = (mq.size() >= 2);
      e.pa  = e.va ? mq[0].pc   : 32'd0;
      e.ia  = e.va ? mq[0].inst : NOP;
      e.pb  = e.vb ? mq[1].pc   : 32'd0;
      e.ib  = e.vb ? mq[1].inst : NOP;
      e.cnt = 4'(mq.size());
      e.st  = (mq.size() > DEPTH - 2);
      return e;
   endfunction

   // One cycle: called just after a rising edge, returns just after the next one.
   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] dq, input logic fl);
      int take;
      bit accept;
      bus.in_valid  = v;
      bus.in_pc     = pc;
      bus.in_inst_a = a;
      bus.in_inst_b = b;
      bus.deq_count = dq;
      bus.flush     = fl;
      exp_q.push_back(model_view());
      accept = v && !(mq.size() > DEPTH - 2) && !fl;
      @(posedge clk);
      if (fl) begin
         mq.delete();
      end else begin
         take = (dq == 2'd3) ? 2 : int'(dq);
         if (take > mq.size()) take = mq.size();
         for (int i = 0; i < take; i++) void'(mq.pop_front());
         if (accept) begin
            mq.push_back({pc, a});
            mq.push_back({pc + 32'd4, b});
         end
      end
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("valid_a", 64'(bus.out_valid_a), 64'(e.va));
            check("pc_a",    64'(bus.out_pc_a),    64'(e.pa));
            check("inst_a",  64'(bus.out_inst_a),  64'(e.ia));
            check("valid_b", 64'(bus.out_valid_b), 64'(e.vb));
            check("pc_b",    64'(bus.out_pc_b),    64'(e.pb));
            check("inst_b",  64'(bus.out_inst_b),  64'(e.ib));
            check("count",   64'(bus.count),       64'(e.cnt));
            check("stall",   64'(bus.stall),       64'(e.st));
         end
      end
   end

   initial begin : stim
      logic [31:0] pc;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_pc     = '0;
      bus.in_inst_a = '0;
      bus.in_inst_b = '0;
      bus.deq_count = '0;
      bus.flush     = 1'b0;
      #12;
      check("rst_count",  64'(bus.count),       64'd0);
      check("rst_valid",  64'(bus.out_valid_a), 64'd0);
      check("rst_inst_a", 64'(bus.out_inst_a),  64'(NOP));
      check("rst_stall",  64'(bus.stall),       64'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // First pair visible next cycle.
      drive(1, 32'h100, 32'hAAAA0001, 32'hBBBB0002, 0, 0);
      check("t1_count", 64'(bus.count),      64'd2);
      check("t1_pc_b",  64'(bus.out_pc_b),   64'h104);
      check("t1_inst_b",64'(bus.out_inst_b), 64'hBBBB0002);

      // Fill to 8, then an extra pair must be refused.
      for (int i = 1; i < 4; i++)
         drive(1, 32'h100 + 32'(8*i), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 0, 0);
      check("full_count", 64'(bus.count), 64'd8);
      check("full_stall", 64'(bus.stall), 64'd1);
      drive(1, 32'h200, 32'hDEAD0000, 32'hDEAD0001, 0, 0);
      check("hold_count", 64'(bus.count),    64'd8);
      check("hold_pc_a",  64'(bus.out_pc_a), 64'h100);

      // Stalled pair dropped while two retire.
      drive(1, 32'h300, 32'hDEAD0002, 32'hDEAD0003, 2, 0);
      check("t3_count", 64'(bus.count),    64'd6);
      check("t3_pc_a",  64'(bus.out_pc_a), 64'h108);

      // Drain with over-request at count=1.
      drive(0, 0, 0, 0, 3, 0);
      drive(0, 0, 0, 0, 2, 0);
      drive(0, 0, 0, 0, 1, 0);
      check("t4_one", 64'(bus.count), 64'd1);
      drive(0, 0, 0, 0, 2, 0);
      check("t4_zero",  64'(bus.count),      64'd0);
      check("t4_inst",  64'(bus.out_inst_a), 64'(NOP));
      check("t4_pc",    64'(bus.out_pc_a),   64'd0);

      // Steady stream across pointer wrap.
      for (int i = 0; i < 10; i++)
         drive(1, 32'h1000 + 32'(8*i), $urandom, $urandom, 2, 0);

      // Flush at count 6 with activity on both sides.
      drive(1, 32'h2000, $urandom, $urandom, 0, 0);
      drive(1, 32'h2008, $urandom, $urandom, 0, 0);
      check("t6_six", 64'(bus.count), 64'd6);
      drive(1, 32'h2010, $urandom, $urandom, 1, 1);
      check("flush_count", 64'(bus.count),       64'd0);
      check("flush_valid", 64'(bus.out_valid_b), 64'd0);

      // Async reset mid-stream.
      drive(1, 32'h3000, $urandom, $urandom, 0, 0);
      drive(1, 32'h3008, $urandom, $urandom, 0, 0);
      bus.in_valid = 1'b0;
      reset = 1'b1;
      #2;
      check("arst_count", 64'(bus.count), 64'd0);
      check("arst_stall", 64'(bus.stall), 64'd0);
      mq.delete();
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         pc = {$urandom_range(0, 32'h00FFFFFF), 2'b00};
         drive(($urandom_range(0, 9) < 7), pc, $urandom, $urandom,
               2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
      end

      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inst_pair_queue.md
Name: inst_pair_queue

Overview:
- Instruction queue between the dual-issue fetch stage and decode/issue; the consumer end of fetch's two-instruction output interface.
- Each cycle it accepts one fetched pair (PC, PC+4) and presents the two oldest instructions to decode in order.
- Decode retires 0, 1 or 2 of them per cycle.
- Drives the stall back into fetch when it cannot absorb another pair; clears on pipeline flush.

Parameters:
DEPTH, 8, number of single-instruction entries; power of two, >= 4.
NOP, 32'h00000013, instruction word driven on an invalid output slot (addi x0,x0,0).

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
flush  input  1  discard all queued and incoming instructions
in_valid  input  1  fetch presents a pair this cycle
in_pc  input  32  PC of in_inst_a; in_inst_b is at in_pc+4
in_inst_a  input  32  older fetched instruction
in_inst_b  input  32  younger fetched instruction
stall  output  1  to fetch: hold PC, pair will not be accepted
deq_count  input  2  decode consumes 0/1/2 head entries this cycle; 3 treated as 2
out_valid_a  output  1  head entry valid
out_pc_a  output  32  head entry PC
out_inst_a  output  32  head entry instruction
out_valid_b  output  1  head+1 entry valid
out_pc_b  output  32  head+1 entry PC
out_inst_b  output  32  head+1 entry instruction
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: DEPTH entries of {pc[31:0], inst[31:0]}. Circular buffer with head/tail pointers of $clog2(DEPTH) bits; pointers wrap modulo DEPTH. count is kept separately so full and empty are unambiguous.
- Reset (async): head=0, tail=0, count=0. All outputs follow from count=0: out_valid_a/b=0, out_inst_a/b=NOP, out_pc_a/b=0, stall=0. Entry storage is not reset.
- stall: combinational, = (count > DEPTH-2). Computed from current count only, not from same-cycle dequeue; conservative by design.
- Enqueue: when in_valid && !stall && !flush:
  - entry[tail] = {in_pc, in_inst_a}; entry[tail+1] = {in_pc+4, in_inst_b} (pointer wraps).
  - tail += 2.
  - in_valid while stall=1 is ignored; fetch holds and re-presents the pair.
- Dequeue: eff = min(deq_count==3 ? 2 : deq_count, count); head += eff. Over-request is clamped, never underflows.
- Same-cycle enqueue and dequeue: count_next = count + (enq?2:0) - eff.
- Flush (synchronous, highest priority): head=0, tail=0, count=0 next edge; enqueue and dequeue that cycle are ignored. Outputs keep showing current contents during the flush cycle; next cycle they are invalid.
- Read side, first-word-fall-through (combinational from registered state):
  - out_valid_a = count>=1; out_valid_b = count>=2.
  - Slot a = entry[head]; slot b = entry[head+1] (wraps).
  - An invalid slot drives inst=NOP, pc=0.
- Latency: pair enqueued at edge N is visible on out_* after edge N; no enqueue-to-dequeue bypass in the same cycle.
- Invariant: count <= DEPTH always. Entries leave in strict program order; a leaves before b.

Test Plan:
1. Reset, then in_valid=1, in_pc=0x100, a=0xAAAA0001, b=0xBBBB0002, deq_count=0 for 1 cycle -> next cycle count=2, out_pc_a=0x100, out_inst_a=0xAAAA0001, out_pc_b=0x104, out_inst_b=0xBBBB0002, both valid.
2. Fill with DEPTH=8 and deq_count=0: stall=0 at counts 0,2,4; stall=1 at count=8. Hold in_valid=1 one extra cycle -> count stays 8, no overwrite.
3. With count=8, stall=1, in_valid=1, deq_count=2 -> pair not accepted; next cycle count=6, stall=0, head advanced by 2.
4. count=1 with deq_count=2 -> count=0, no underflow. Then out_valid_a=0, out_inst_a=0x00000013, out_pc_a=0.
5. Wrap-around: steady in_valid with deq_count=2 for 10 cycles -> PCs on out_pc_a/out_pc_b increase by 8 per cycle with no gaps or duplicates across the pointer wrap.
6. count=6, in_valid=1, deq_count=1, flush=1 -> next cycle count=0, all outputs invalid. Then assert reset mid-stream at count=4 -> immediate count=0, stall=0 without waiting for a clock edge.
